// File: rtl/aes_byte_stream_io_if.sv
// aes_byte_stream_io_if: byte-in, block-out, result-in, byte-out handshake bundle
interface aes_byte_stream_io_if #(parameter int NBYTES = 16);
  logic [7:0] in_byte;
  logic in_valid;
  logic in_ready;
  logic [8*NBYTES-1:0] block_o;
  logic block_valid;
  logic block_ready;
  logic [8*NBYTES-1:0] result_i;
  logic result_valid;
  logic [7:0] out_byte;
  logic out_valid;
  logic out_ready;
  modport master (
    output in_byte, in_valid, block_ready, result_i, result_valid, out_ready,
    input in_ready, block_o, block_valid, out_byte, out_valid
  );
  modport slave (
    input in_byte, in_valid, block_ready, result_i, result_valid, out_ready,
    output in_ready, block_o, block_valid, out_byte, out_valid
  );
endinterface

// File: rtl/aes_byte_stream_io.sv
// aes_byte_stream_io: assembles NBYTES input bytes into a block, hands it to the core, streams the result back MSB first
module aes_byte_stream_io #(
  parameter int NBYTES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  aes_byte_stream_io_if.slave bus,
  output logic [1:0] state_o
);
  localparam int W = 8 * NBYTES;
  localparam int CW = $clog2(NBYTES);
  typedef enum logic [1:0] {LOAD, ISSUE, WAIT, UNLOAD} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [W-1:0] block;
  logic [W-1:0] shift;
  logic last;
  assign last = cnt == CW'(NBYTES - 1);
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      state <= LOAD;
      cnt <= '0;
      block <= '0;
      shift <= '0;
    end else begin
      case (state)
        LOAD: if (bus.in_valid) begin
          block <= {block[W-9:0], bus.in_byte};
          cnt <= last ? '0 : cnt + CW'(1);
          if (last) state <= ISSUE;
        end
        ISSUE: if (bus.block_ready) state <= WAIT;
        WAIT: if (bus.result_valid) begin
          shift <= bus.result_i;
          state <= UNLOAD;
        end
        UNLOAD: if (bus.out_ready) begin
          shift <= {shift[W-9:0], 8'h00};
          cnt <= last ? '0 : cnt + CW'(1);
          if (last) state <= LOAD;
        end
      endcase
    end
  end
  // every output is a register or a decode of the state register
  always_comb begin
    bus.in_ready = state == LOAD;
    bus.block_valid = state == ISSUE;
    bus.out_valid = state == UNLOAD;
    bus.block_o = block;
    bus.out_byte = shift[W-1:W-8];
    state_o = state;
  end
endmodule

// File: tb/tb_aes_byte_stream_io.sv
// tb_aes_byte_stream_io: directed + randomized checks of byte assembly, block handshake, result unload, flush and reset
module tb_aes_byte_stream_io;
  localparam int NB = 16;
  localparam logic [127:0] FIPS_PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  logic clk = 0;
  logic rst_n = 0;
  logic flush = 0;
  logic [1:0] state_o;
  int vectors = 0;
  int miscompares = 0;
  aes_byte_stream_io_if #(.NBYTES(NB)) bus();
  aes_byte_stream_io #(.NBYTES(NB)) dut (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus), .state_o(state_o));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction
  function automatic logic [127:0] core(input logic [127:0] b);
    return (b == FIPS_PT) ? FIPS_CT : ({b[63:0], b[127:64]} ^ 128'h5a5a_3c3c_0f0f_a5a5_c3c3_f0f0_1234_abcd);
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    bus.in_valid = 0;
    bus.in_byte = 0;
    bus.block_ready = 0;
    bus.result_valid = 0;
    bus.result_i = 0;
    bus.out_ready = 0;
  endtask
  task automatic do_reset();
    rst_n = 0;
    idle();
    step();
    step();
    chk("rst_state", state_o, 0);
    chk("rst_block_o", bus.block_o, 128'h0);
    chk("rst_out_byte", bus.out_byte, 8'h00);
    chk("rst_block_valid", bus.block_valid, 1'b0);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    rst_n = 1;
    step();
    chk("rst_in_ready", bus.in_ready, 1'b1);
  endtask
  task automatic load_block(input logic [127:0] blk, input int gap, input bit junk_rv);
    for (int i = 0; i < NB; i++) begin
      repeat (gap) begin
        bus.in_valid = 0;
        bus.in_byte = 8'($urandom);
        step();
      end
      bus.in_valid = 1;
      bus.in_byte = blk[127-8*i -: 8];
      bus.result_valid = junk_rv;
      bus.result_i = rnd128();
      chk("load_in_ready", bus.in_ready, 1'b1);
      chk("load_state", state_o, 0);
      step();
    end
    bus.in_valid = 0;
    bus.result_valid = 0;
    chk("block_valid_latency", bus.block_valid, 1'b1);
    chk("issue_state", state_o, 1);
    chk("block_o", bus.block_o, blk);
    chk("issue_in_ready", bus.in_ready, 1'b0);
  endtask
  task automatic issue(input logic [127:0] blk, input int hold, input bit spurious);
    bus.result_valid = spurious;
    bus.result_i = ~blk;
    for (int c = 0; c < hold; c++) begin
      bus.block_ready = 0;
      bus.in_valid = 1;
      bus.in_byte = 8'($urandom);
      step();
      chk("hold_block_valid", bus.block_valid, 1'b1);
      chk("hold_block_o", bus.block_o, blk);
      chk("hold_in_ready", bus.in_ready, 1'b0);
      chk("hold_state", state_o, 1);
    end
    bus.in_valid = 0;
    bus.block_ready = 1;
    step();
    bus.block_ready = 0;
    bus.result_valid = 0;
    chk("wait_state", state_o, 2);
    chk("wait_block_valid", bus.block_valid, 1'b0);
    chk("wait_out_valid", bus.out_valid, 1'b0);
  endtask
  task automatic await_result(input logic [127:0] blk, input bit junk_in, output logic [127:0] res);
    res = core(blk);
    bus.in_valid = junk_in;
    bus.in_byte = 8'($urandom);
    repeat (2) begin
      step();
      chk("wait_hold_state", state_o, 2);
      chk("wait_block_o", bus.block_o, blk);
    end
    bus.result_i = res;
    bus.result_valid = 1;
    step();
    bus.result_valid = 0;
    bus.result_i = rnd128();
    chk("unload_state", state_o, 3);
    chk("unload_out_valid", bus.out_valid, 1'b1);
    chk("first_out_byte", bus.out_byte, res[127:120]);
  endtask
  task automatic unload(input logic [127:0] res, input logic [127:0] blk, input bit rnd, input int stop_after);
    int k = 0;
    int n = 0;
    while (k < stop_after && n < 400) begin
      bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      chk("out_valid", bus.out_valid, 1'b1);
      chk("out_byte", bus.out_byte, res[127-8*k -: 8]);
      chk("unload_block_o", bus.block_o, blk);
      step();
      if (bus.out_ready) k++;
      n++;
    end
    if (n >= 400) chk("unload_timeout", k, stop_after);
    bus.out_ready = 0;
    bus.in_valid = 0;
    if (stop_after == NB) begin
      chk("done_state", state_o, 0);
      chk("done_in_ready", bus.in_ready, 1'b1);
      chk("done_out_valid", bus.out_valid, 1'b0);
    end
  endtask
  task automatic round(input logic [127:0] blk, input int gap, input int hold, input bit spurious, input bit junk_in, input bit rnd);
    logic [127:0] res;
    load_block(blk, gap, spurious);
    issue(blk, hold, spurious);
    await_result(blk, junk_in, res);
    unload(res, blk, rnd, NB);
  endtask
  initial begin
    logic [127:0] blk;
    logic [127:0] res;
    do_reset();
    round(FIPS_PT, 0, 0, 0, 0, 0);
    round(rnd128(), 0, 5, 0, 0, 1);
    round(rnd128(), 2, 1, 0, 1, 1);
    round(rnd128(), 1, 2, 1, 0, 0);
    for (int i = 0; i < 7; i++) begin
      bus.in_valid = 1;
      bus.in_byte = 8'($urandom);
      step();
    end
    flush = 1;
    bus.in_byte = 8'haa;
    step();
    flush = 0;
    bus.in_valid = 0;
    chk("flush_state", state_o, 0);
    chk("flush_block_o", bus.block_o, 128'h0);
    chk("flush_in_ready", bus.in_ready, 1'b1);
    round(rnd128(), 0, 0, 0, 0, 0);
    blk = rnd128();
    load_block(blk, 0, 0);
    issue(blk, 0, 0);
    await_result(blk, 0, res);
    unload(res, blk, 0, 4);
    rst_n = 0;
    step();
    chk("rst_mid_out_valid", bus.out_valid, 1'b0);
    chk("rst_mid_in_ready", bus.in_ready, 1'b1);
    chk("rst_mid_out_byte", bus.out_byte, 8'h00);
    chk("rst_mid_state", state_o, 0);
    rst_n = 1;
    step();
    for (int r = 0; r < 4; r++)
      round(rnd128(), $urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/aes_byte_stream_io.md
Name: aes_byte_stream_io

Overview:
Byte-serial front/back end for the 128-bit AES core. It assembles 16 input bytes into a 128-bit plaintext block and hands it to the core with a valid/ready handshake. It then captures the 128-bit result and streams it back out one byte at a time, MSB first. It sits between the 8-bit tile pins (ui_in/uo_out) and AES_Encrypt/AES_Decrypt, so the top level can drive full blocks instead of a single variable byte.

Parameters:
NBYTES, 16, bytes per block; block width is 8*NBYTES (128 at default)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  synchronous active-low reset
flush  input  1  synchronous abort; returns to LOAD, discards partial block/result
in_byte  input  8  input byte; first accepted byte becomes block_o[127:120]
in_valid  input  1  in_byte valid
in_ready  output  1  block accepts a byte this cycle
block_o  output  128  assembled plaintext block to core
block_valid  output  1  block_o valid, held until accepted
block_ready  input  1  core accepts block_o
result_i  input  128  core result (ciphertext/plaintext)
result_valid  input  1  result_i valid
out_byte  output  8  output byte; first byte = result[127:120]
out_valid  output  1  out_byte valid
out_ready  input  1  consumer takes out_byte
state_o  output  2  current state: LOAD=0, ISSUE=1, WAIT=2, UNLOAD=3

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=LOAD, byte counter=0.
  - block_o, shift/result registers and out_byte = 0.
  - in_ready=1 from the first cycle after reset deasserts; block_valid=0, out_valid=0.
- Handshakes: a transfer occurs on a rising edge where valid&&ready. A valid signal, once raised by this block, is never dropped and its data never changes until the transfer completes.
- LOAD:
  - in_ready=1.
  - Each in_valid transfer shifts in_byte in at the LSB end ({block[119:0], in_byte}) and increments the counter.
  - On the NBYTES-th transfer: counter clears to 0, next state=ISSUE.
  - block_valid rises the cycle after the last byte is accepted (latency 1).
- ISSUE:
  - block_valid=1, in_ready=0, block_o stable.
  - On block_ready: next state=WAIT. block_valid is 0 in the following cycle.
- WAIT:
  - On result_valid: result_i is captured into the output shift register, next state=UNLOAD.
  - The core is combinational, so the top ties result_valid to the registered accept. Same-cycle result_valid with block_ready in ISSUE is ignored; only WAIT samples it.
- UNLOAD:
  - out_valid=1, out_byte = shift[127:120].
  - On out_ready: shift left 8 and increment the counter.
  - On the NBYTES-th transfer: next state=LOAD, out_valid=0 and in_ready=1 the next cycle.
- Ignored inputs:
  - in_valid is ignored outside LOAD (in_ready=0).
  - result_valid is ignored outside WAIT.
  - block_ready is ignored outside ISSUE.
- Counter: 4 bits (clog2(NBYTES)), values 0..NBYTES-1. No wrap beyond NBYTES-1; terminal count triggers the state change.
- flush:
  - Same effect as reset on state, counter, block_valid and out_valid.
  - Data registers are cleared to 0.
  - Priority over every simultaneous transfer in the same cycle; a byte presented that cycle is dropped.
- rst_n low mid-operation: immediate return to reset values at that edge; any partial block or result is lost.
- No combinational path from any input to any output: all outputs are registered or decoded from registered state.

Test Plan:
- FIPS-197 round trip: reset, send bytes 00,11,22,...,ff with in_valid held high and block_ready held high; tie result_i to AES_Encrypt(block_o, key 000102...0f), result_valid=1.
  - block_o=00112233445566778899aabbccddeeff, and block_valid rises exactly 1 cycle after byte 16.
  - out_byte stream = 69,c4,e0,d8,6a,7b,04,30,d8,cd,b7,80,70,b4,c5,5a.
  - Then state_o=0 and in_ready=1.
- Backpressure: block_ready=0 for 5 cycles after block_valid rises.
  - block_valid stays 1 and block_o stays unchanged; in_ready=0 while in ISSUE.
  - Randomly toggle out_ready in UNLOAD: byte order is unchanged, and no byte is duplicated or skipped.
- Gapped input: in_valid pulses every 3rd cycle for 16 bytes.
  - Only those 16 bytes are assembled; ISSUE is entered only after the 16th byte.
  - in_valid asserted during WAIT/UNLOAD causes no change in block_o.
- Flush mid-load: after 7 bytes, assert flush together with in_valid.
  - Next cycle: state_o=0, counter 0, block_o=0.
  - A new 16-byte block then assembles correctly with no leftover bytes.
- Reset mid-unload: pull rst_n low after 4 output bytes.
  - Next cycle: out_valid=0, in_ready=1, out_byte=0, state_o=0.
- Spurious result_valid: assert result_valid in LOAD and ISSUE.
  - No capture occurs, and the state sequence is unaffected.
